// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared types and helpers for the memory-access pipeline stage.
//   state_t     : stage FSM states (IDLE, WAIT)
//   SZ_*        : legal transfer byte counts
//   is_aligned  : natural-alignment test of an address against a byte count
// -----------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    // Only the low three address bits matter for alignment up to 8 bytes.
    // Sizes outside the legal set are reported as misaligned.
    function automatic logic is_aligned(input logic [2:0] addr, input logic [3:0] size);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addr[0] == 1'b0);
            SZ_W:    ok = (addr[1:0] == 2'b00);
            SZ_D:    ok = (addr == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Bundles the execute-side inputs, the data-memory req/ack bus and the
// writeback outputs of the memory-access stage.
//   master : the stage itself (drives stall, mem_*, out_*)
//   slave  : the surrounding pipeline / memory model
// -----------------------------------------------------------------------------
interface mem_access_stage_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int REG_W      = 5
);
    // execute side
    logic                  in_valid;
    logic                  in_mem_read;
    logic                  in_mem_write;
    logic [3:0]            in_xfer_size;
    logic                  in_sign_ext;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_wdata;
    logic [DATA_WIDTH-1:0] in_mov;
    logic [REG_W-1:0]      in_rd;
    logic                  stall;

    // data memory
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_size;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    // writeback side
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_alu;
    logic [DATA_WIDTH-1:0] out_mov;
    logic [DATA_WIDTH-1:0] out_load;
    logic [REG_W-1:0]      out_rd;
    logic                  out_fault;

    modport master (
        input  in_valid, in_mem_read, in_mem_write, in_xfer_size, in_sign_ext,
        input  in_addr, in_wdata, in_mov, in_rd,
        input  mem_rdata, mem_ack,
        output stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        output out_valid, out_alu, out_mov, out_load, out_rd, out_fault
    );

    modport slave (
        output in_valid, in_mem_read, in_mem_write, in_xfer_size, in_sign_ext,
        output in_addr, in_wdata, in_mov, in_rd,
        output mem_rdata, mem_ack,
        input  stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        input  out_valid, out_alu, out_mov, out_load, out_rd, out_fault
    );

endinterface

// File: rtl/mem_access_stage_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load formatter: keeps the low size*8 bits of the read data
// and sign- or zero-extends them to DATA_WIDTH.
//   rdata_i    : raw read data from memory
//   size_i     : byte count (1, 2, 4, 8)
//   sign_ext_i : 1 = sign-extend, 0 = zero-extend
//   data_o     : extended load value
// -----------------------------------------------------------------------------
module load_extend
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [3:0]            size_i,
    input  logic                  sign_ext_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    int   nbits;
    logic sign_bit;

    always_comb begin
        case (size_i)
            SZ_B:    nbits = 8;
            SZ_H:    nbits = 16;
            SZ_W:    nbits = 32;
            default: nbits = DATA_WIDTH;
        endcase
        // Sizes wider than the datapath never reach memory; clamp so the
        // index below stays in range regardless.
        if (nbits > DATA_WIDTH) begin
            nbits = DATA_WIDTH;
        end

        sign_bit = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == nbits - 1) begin
                sign_bit = rdata_i[i];
            end
        end

        for (int i = 0; i < DATA_WIDTH; i++) begin
            data_o[i] = (i < nbits) ? rdata_i[i] : (sign_ext_i & sign_bit);
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Variable-latency memory-access stage between execute and writeback.
// Non-memory ops pass through in one cycle; loads/stores are issued over a
// req/ack bus while upstream is stalled. Misaligned/illegal accesses and
// accesses that see no ack within TIMEOUT cycles complete with out_fault.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_access_stage_if.master
//                in_*  execute-side op, stall back to execute
//                mem_* data-memory request / response
//                out_* registered writeback bundle (one-cycle out_valid)
// -----------------------------------------------------------------------------
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int REG_W      = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_stage_if.master bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [DATA_WIDTH-1:0] mov_q,       mov_d;
    logic [REG_W-1:0]      rd_q,        rd_d;
    logic [3:0]            size_q,      size_d;
    logic                  sext_q,      sext_d;
    logic                  we_q,        we_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_alu_q,   out_alu_d;
    logic [DATA_WIDTH-1:0] out_mov_q,   out_mov_d;
    logic [DATA_WIDTH-1:0] out_load_q,  out_load_d;
    logic [REG_W-1:0]      out_rd_q,    out_rd_d;
    logic                  out_fault_q, out_fault_d;

    logic                  is_mem;
    logic                  size_ok;
    logic                  acc_fault;
    logic [DATA_WIDTH-1:0] ext_data;

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extend (
        .rdata_i    (bus.mem_rdata),
        .size_i     (size_q),
        .sign_ext_i (sext_q),
        .data_o     (ext_data)
    );

    // Access legality of the op currently offered by execute. A doubleword
    // is only legal when the datapath is 64 bits wide.
    assign is_mem    = bus.in_mem_read | bus.in_mem_write;
    assign size_ok   = (bus.in_xfer_size == SZ_B) || (bus.in_xfer_size == SZ_H) ||
                       (bus.in_xfer_size == SZ_W) ||
                       ((bus.in_xfer_size == SZ_D) && (DATA_WIDTH == 64));
    assign acc_fault = is_mem && (!size_ok ||
                                  (bus.in_mem_read && bus.in_mem_write) ||
                                  !is_aligned(bus.in_addr[2:0], bus.in_xfer_size));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mov_d       = mov_q;
        rd_d        = rd_q;
        size_d      = size_q;
        sext_d      = sext_q;
        we_d        = we_q;
        out_valid_d = 1'b0;
        out_alu_d   = out_alu_q;
        out_mov_d   = out_mov_q;
        out_load_d  = out_load_q;
        out_rd_d    = out_rd_q;
        out_fault_d = out_fault_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    addr_d  = bus.in_addr;
                    wdata_d = bus.in_wdata;
                    mov_d   = bus.in_mov;
                    rd_d    = bus.in_rd;
                    size_d  = bus.in_xfer_size;
                    sext_d  = bus.in_sign_ext;
                    we_d    = bus.in_mem_write;
                    if (is_mem && !acc_fault) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else begin
                        // Pass-through or rejected access: retire next cycle.
                        out_valid_d = 1'b1;
                        out_alu_d   = DATA_WIDTH'(bus.in_addr);
                        out_mov_d   = bus.in_mov;
                        out_rd_d    = bus.in_rd;
                        out_load_d  = '0;
                        out_fault_d = acc_fault;
                    end
                end
            end

            WAIT: begin
                // Ack on the last counted cycle still completes normally.
                if (bus.mem_ack) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_alu_d   = DATA_WIDTH'(addr_q);
                    out_mov_d   = mov_q;
                    out_rd_d    = rd_q;
                    out_load_d  = we_q ? '0 : ext_data;
                    out_fault_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_alu_d   = DATA_WIDTH'(addr_q);
                    out_mov_d   = mov_q;
                    out_rd_d    = rd_q;
                    out_load_d  = '0;
                    out_fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mov_q       <= '0;
            rd_q        <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            we_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_alu_q   <= '0;
            out_mov_q   <= '0;
            out_load_q  <= '0;
            out_rd_q    <= '0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mov_q       <= mov_d;
            rd_q        <= rd_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            we_q        <= we_d;
            out_valid_q <= out_valid_d;
            out_alu_q   <= out_alu_d;
            out_mov_q   <= out_mov_d;
            out_load_q  <= out_load_d;
            out_rd_q    <= out_rd_d;
            out_fault_q <= out_fault_d;
        end
    end

    // The request is live for exactly the WAIT state; the captured operands
    // keep the bus stable until the access ends.
    assign bus.stall     = (state_q == WAIT);
    assign bus.mem_req   = (state_q == WAIT);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_size  = size_q;

    assign bus.out_valid = out_valid_q;
    assign bus.out_alu   = out_alu_q;
    assign bus.out_mov   = out_mov_q;
    assign bus.out_load  = out_load_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_fault = out_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed ops, a transaction-level expected
// queue, and a per-cycle compare process on the falling edge.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .REG_W(5)) bus ();

    mem_access_stage #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (64),
        .REG_W      (5),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [63:0] alu;
        logic [63:0] mov;
        logic [63:0] load;
        logic [4:0]  rd;
        logic        fault;
    } exp_t;

    exp_t expq[$];
    exp_t last;
    exp_t cmp_e;

    // Outstanding memory request as the bench expects to see it on the bus.
    logic        cur_active = 1'b0;
    logic [63:0] cur_addr, cur_wdata;
    logic        cur_we;
    logic [3:0]  cur_size;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected load value: mask to the transfer width, then extend.
    function automatic logic [63:0] model_load(input logic [63:0] rdata, input int bytes,
                                               input logic sext);
        logic [63:0] mask;
        logic [63:0] v;
        int nb;
        nb   = bytes * 8;
        mask = (nb >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nb) - 64'd1);
        v    = rdata & mask;
        if (sext && nb < 64 && (((rdata >> (nb - 1)) & 64'd1) != 64'd0)) v = v | ~mask;
        return v;
    endfunction

    function automatic logic model_fault(input logic r, input logic w, input int bytes,
                                         input logic [63:0] addr);
        if (!(r || w)) return 1'b0;
        if (r && w) return 1'b1;
        if (!(bytes == 1 || bytes == 2 || bytes == 4 || bytes == 8)) return 1'b1;
        return (addr % 64'(bytes)) != 64'd0;
    endfunction

    // Per-cycle comparison against the expected queue and request state.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    check("out_valid_unexpected", 64'(bus.out_valid), 64'd0);
                end else begin
                    cmp_e = expq.pop_front();
                    check("out_alu",   bus.out_alu,          cmp_e.alu);
                    check("out_mov",   bus.out_mov,          cmp_e.mov);
                    check("out_load",  bus.out_load,         cmp_e.load);
                    check("out_rd",    64'(bus.out_rd),      64'(cmp_e.rd));
                    check("out_fault", 64'(bus.out_fault),   64'(cmp_e.fault));
                    last = cmp_e;
                end
            end else begin
                check("hold_alu",   bus.out_alu,        last.alu);
                check("hold_mov",   bus.out_mov,        last.mov);
                check("hold_load",  bus.out_load,       last.load);
                check("hold_rd",    64'(bus.out_rd),    64'(last.rd));
                check("hold_fault", 64'(bus.out_fault), 64'(last.fault));
            end
            check("mem_req", 64'(bus.mem_req), 64'(cur_active));
            check("stall",   64'(bus.stall),   64'(cur_active));
            if (bus.mem_req && cur_active) begin
                check("mem_addr",  bus.mem_addr,       cur_addr);
                check("mem_wdata", bus.mem_wdata,      cur_wdata);
                check("mem_we",    64'(bus.mem_we),    64'(cur_we));
                check("mem_size",  64'(bus.mem_size),  64'(cur_size));
            end
        end
    end

    // Offer one op, run the memory side, return with the result on the bus.
    // ack_after = k acks in the k-th WAIT cycle; 0 never acks.
    task automatic run_op(input string nm, input logic r, input logic w, input int bytes,
                          input logic sx, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] mv, input logic [4:0] rdi,
                          input logic [63:0] rdat, input int ack_after, output int waits);
        exp_t e;
        logic flt;
        logic goes_mem;
        flt      = model_fault(r, w, bytes, a);
        goes_mem = (r || w) && !flt;
        e.alu    = a;
        e.mov    = mv;
        e.rd     = rdi;
        e.fault  = flt || (goes_mem && (ack_after < 1 || ack_after > TIMEOUT));
        e.load   = (goes_mem && r && !e.fault) ? model_load(rdat, bytes, sx) : 64'd0;
        expq.push_back(e);

        bus.in_valid     = 1'b1;
        bus.in_mem_read  = r;
        bus.in_mem_write = w;
        bus.in_xfer_size = 4'(bytes);
        bus.in_sign_ext  = sx;
        bus.in_addr      = a;
        bus.in_wdata     = wd;
        bus.in_mov       = mv;
        bus.in_rd        = rdi;
        @(posedge clk); #1;
        bus.in_valid     = 1'b0;
        bus.in_addr      = ~a;
        bus.in_wdata     = ~wd;
        bus.in_mov       = ~mv;
        bus.in_rd        = ~rdi;
        bus.in_xfer_size = 4'd8;
        bus.in_sign_ext  = ~sx;

        waits = 0;
        if (goes_mem) begin
            cur_active = 1'b1;
            cur_addr   = a;
            cur_wdata  = wd;
            cur_we     = w;
            cur_size   = 4'(bytes);
            while (bus.stall && waits < TIMEOUT + 4) begin
                waits++;
                if (waits == ack_after) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdat;
                end
                @(posedge clk); #1;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = {$urandom(), $urandom()};
            end
            cur_active = 1'b0;
        end
        check({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({nm, "_stall"}, 64'(bus.stall), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    localparam logic [63:0] RD_PAT = 64'hDEADBEEFCAFEF08D;

    initial begin
        int w;
        exp_t ea, eb;
        last             = '0;
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_mem_read  = 1'b0;
        bus.in_mem_write = 1'b0;
        bus.in_xfer_size = 4'd0;
        bus.in_sign_ext  = 1'b0;
        bus.in_addr      = '0;
        bus.in_wdata     = '0;
        bus.in_mov       = '0;
        bus.in_rd        = '0;
        bus.mem_rdata    = '0;
        bus.mem_ack      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_alu",   bus.out_alu,        64'd0);
        check("rst_out_fault", 64'(bus.out_fault), 64'd0);
        check("rst_mem_req",   64'(bus.mem_req),   64'd0);
        check("rst_stall",     64'(bus.stall),     64'd0);
        reset = 1'b0;

        // Non-memory pass-through
        run_op("nonmem", 0, 0, 8, 0, 64'h1234, 64'h0, 64'h55, 5'd7, 64'h0, 0, w);
        check("nonmem_alu",  bus.out_alu,        64'h1234);
        check("nonmem_mov",  bus.out_mov,        64'h55);
        check("nonmem_rd",   64'(bus.out_rd),    64'd7);
        check("nonmem_load", bus.out_load,       64'd0);
        check("nonmem_req",  64'(bus.mem_req),   64'd0);

        // Back-to-back non-memory ops, one per cycle
        ea = '{alu: 64'hA0, mov: 64'hA1, load: 64'd0, rd: 5'd1, fault: 1'b0};
        eb = '{alu: 64'hB0, mov: 64'hB1, load: 64'd0, rd: 5'd2, fault: 1'b0};
        expq.push_back(ea);
        expq.push_back(eb);
        bus.in_valid = 1'b1; bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0;
        bus.in_addr = 64'hA0; bus.in_mov = 64'hA1; bus.in_rd = 5'd1;
        @(posedge clk); #1;
        check("b2b_first_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_first_rd",    64'(bus.out_rd),    64'd1);
        bus.in_addr = 64'hB0; bus.in_mov = 64'hB1; bus.in_rd = 5'd2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("b2b_second_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_second_rd",    64'(bus.out_rd),    64'd2);

        // Store, ack in the 3rd WAIT cycle
        run_op("store", 0, 1, 8, 0, 64'h0, 64'hDEADBEEFCAFEF00D, 64'h11, 5'd3, 64'h0, 3, w);
        check("store_waits", 64'(w), 64'd3);
        check("store_fault", 64'(bus.out_fault), 64'd0);
        check("store_load",  bus.out_load, 64'd0);

        // Loads with 1-cycle ack
        run_op("ldb_s", 1, 0, 1, 1, 64'h101, 64'h0, 64'h0, 5'd4, RD_PAT, 1, w);
        check("ldb_s_waits", 64'(w), 64'd1);
        check("ldb_s_load", bus.out_load, 64'hFFFFFFFFFFFFFF8D);
        run_op("ldb_z", 1, 0, 1, 0, 64'h102, 64'h0, 64'h0, 5'd5, RD_PAT, 1, w);
        check("ldb_z_load", bus.out_load, 64'h8D);
        run_op("ldw_s", 1, 0, 4, 1, 64'h104, 64'h0, 64'h0, 5'd6, RD_PAT, 1, w);
        check("ldw_s_load", bus.out_load, 64'hFFFFFFFFCAFEF08D);
        run_op("ldw_z", 1, 0, 4, 0, 64'h108, 64'h0, 64'h0, 5'd8, RD_PAT, 1, w);
        check("ldw_z_load", bus.out_load, 64'hCAFEF08D);
        run_op("ldh_s", 1, 0, 2, 1, 64'h10A, 64'h0, 64'h0, 5'd9, RD_PAT, 2, w);
        check("ldh_s_load", bus.out_load, 64'hFFFFFFFFFFFFF08D);
        run_op("ldd", 1, 0, 8, 1, 64'h110, 64'h0, 64'h0, 5'd10, RD_PAT, 1, w);
        check("ldd_load", bus.out_load, 64'hDEADBEEFCAFEF08D);

        // Faulting accesses: no request, fault next cycle
        run_op("mis_w", 1, 0, 4, 0, 64'h6, 64'h0, 64'h0, 5'd11, 64'h0, 1, w);
        check("mis_w_waits", 64'(w), 64'd0);
        check("mis_w_fault", 64'(bus.out_fault), 64'd1);
        check("mis_w_load",  bus.out_load, 64'd0);
        run_op("size3", 1, 0, 3, 0, 64'h0, 64'h0, 64'h0, 5'd12, 64'h0, 1, w);
        check("size3_fault", 64'(bus.out_fault), 64'd1);
        run_op("rw_both", 1, 1, 8, 0, 64'h0, 64'h0, 64'h0, 5'd13, 64'h0, 1, w);
        check("rw_both_fault", 64'(bus.out_fault), 64'd1);
        run_op("mis_h", 0, 1, 2, 0, 64'h1, 64'h77, 64'h0, 5'd14, 64'h0, 1, w);
        check("mis_h_fault", 64'(bus.out_fault), 64'd1);

        // Timeout, then normal recovery
        run_op("tmo", 1, 0, 8, 0, 64'h200, 64'h0, 64'h99, 5'd15, RD_PAT, 0, w);
        check("tmo_req_cycles", 64'(w), 64'd16);
        check("tmo_fault", 64'(bus.out_fault), 64'd1);
        run_op("post_tmo", 1, 0, 2, 0, 64'h202, 64'h0, 64'h0, 5'd16, RD_PAT, 2, w);
        check("post_tmo_fault", 64'(bus.out_fault), 64'd0);
        check("post_tmo_load",  bus.out_load, 64'hF08D);

        // Ack on the final counted cycle beats the timeout
        run_op("ack_last", 1, 0, 1, 0, 64'h300, 64'h0, 64'h0, 5'd17, RD_PAT, TIMEOUT, w);
        check("ack_last_waits", 64'(w), 64'd16);
        check("ack_last_fault", 64'(bus.out_fault), 64'd0);
        check("ack_last_load",  bus.out_load, 64'h8D);

        // Ack while idle is ignored
        bus.mem_ack = 1'b1; bus.mem_rdata = RD_PAT;
        repeat (2) @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        check("idle_ack_valid", 64'(bus.out_valid), 64'd0);
        check("idle_ack_stall", 64'(bus.stall), 64'd0);

        // Reset in the 2nd WAIT cycle abandons the access
        bus.in_valid = 1'b1; bus.in_mem_read = 1'b1; bus.in_mem_write = 1'b0;
        bus.in_xfer_size = 4'd4; bus.in_sign_ext = 1'b0;
        bus.in_addr = 64'h400; bus.in_mov = 64'h5; bus.in_rd = 5'd18; bus.in_wdata = 64'h0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cur_active = 1'b1; cur_addr = 64'h400; cur_wdata = 64'h0; cur_we = 1'b0; cur_size = 4'd4;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cur_active = 1'b0;
        last = '0;
        check("rst_wait_req",   64'(bus.mem_req),   64'd0);
        check("rst_wait_stall", 64'(bus.stall),     64'd0);
        check("rst_wait_valid", 64'(bus.out_valid), 64'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = RD_PAT;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        check("late_ack_valid", 64'(bus.out_valid), 64'd0);
        check("late_ack_req",   64'(bus.mem_req),   64'd0);

        run_op("post_rst", 0, 0, 8, 0, 64'h42, 64'h0, 64'h43, 5'd19, 64'h0, 0, w);
        check("post_rst_alu", bus.out_alu, 64'h42);
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 64'(expq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
